// File: rtl/uart_apb_bridge.sv
// UART-to-APB master bridge: framed byte commands on uart_rx become single APB
// transfers; an ack, NAK or 4 bytes of read data go back on uart_tx.
module uart_apb_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 1000000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [19:0] paddr,
    output logic        pwrite,
    output logic        psel,
    output logic        penable,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    output logic        busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int TW = $clog2(TIMEOUT_CLKS + 2);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, SETUP, ACCESS, RESP} state_t;

    logic          rx_s1, rx_s2, rx_prev, rx_active, rx_valid;
    logic [CW-1:0] rx_cnt;
    logic [3:0]    rx_idx;
    logic [7:0]    rx_shift;

    logic          tx_active, tx_start, tx_done;
    logic [7:0]    tx_byte;
    logic [9:0]    tx_frame;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_idx;

    state_t        state, state_next;
    logic          is_write, tmo_hit;
    logic [1:0]    byte_cnt, resp_left;
    logic [19:0]   addr_sh;
    logic [23:0]   data_sh;
    logic [23:0]   rdata;
    logic [TW-1:0] tmo_cnt;

    // RX: rx_idx 0 is the start bit (checked at half a bit), 1..8 data, 9 stop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            rx_active <= 1'b0;
            rx_cnt    <= '0;
            rx_idx    <= 4'd0;
            rx_shift  <= 8'h00;
            rx_valid  <= 1'b0;
        end else begin
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_valid <= 1'b0;
            if (!rx_active) begin
                if (rx_prev && !rx_s2) begin
                    rx_active <= 1'b1;
                    rx_cnt    <= '0;
                    rx_idx    <= 4'd0;
                end
            end else if (rx_idx == 4'd0) begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt <= '0;
                    if (rx_s2) rx_active <= 1'b0;
                    else       rx_idx    <= 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + 1'b1;
                end
            end else if (rx_cnt == BIT_LAST) begin
                rx_cnt <= '0;
                if (rx_idx == 4'd9) begin
                    rx_active <= 1'b0;
                    rx_valid  <= rx_s2;
                end else begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_idx   <= rx_idx + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + 1'b1;
            end
        end
    end

    // TX: a new tx_start in the last stop-bit cycle chains bytes with no gap
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_active <= 1'b0;
            tx_frame  <= '1;
            tx_cnt    <= '0;
            tx_idx    <= 4'd0;
        end else if (tx_start) begin
            tx_active <= 1'b1;
            tx_frame  <= {1'b1, tx_byte, 1'b0};
            tx_cnt    <= '0;
            tx_idx    <= 4'd0;
        end else if (tx_active) begin
            if (tx_cnt == BIT_LAST) begin
                tx_cnt <= '0;
                if (tx_idx == 4'd9) tx_active <= 1'b0;
                else                tx_idx    <= tx_idx + 4'd1;
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    assign tx_done = tx_active && (tx_idx == 4'd9) && (tx_cnt == BIT_LAST);
    assign uart_tx = !tx_active || tx_frame[tx_idx];
    assign tmo_hit = (TIMEOUT_CLKS != 0) && (tmo_cnt == TW'(TIMEOUT_CLKS));

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        tx_byte    = 8'h00;
        case (state)
            IDLE: if (rx_valid) begin
                if (rx_shift == CMD_W || rx_shift == CMD_R) begin
                    state_next = ADDR;
                end else begin
                    state_next = RESP;
                    tx_start   = 1'b1;
                    tx_byte    = NAK;
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    if (byte_cnt == 2'd2) state_next = is_write ? DATA : SETUP;
                end else if (tmo_hit) begin
                    state_next = IDLE;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    if (byte_cnt == 2'd3) state_next = SETUP;
                end else if (tmo_hit) begin
                    state_next = IDLE;
                end
            end
            SETUP: state_next = ACCESS;
            ACCESS: begin
                state_next = RESP;
                tx_start   = 1'b1;
                tx_byte    = is_write ? ACK : prdata[31:24];
            end
            RESP: if (tx_done) begin
                if (resp_left == 2'd0) begin
                    state_next = IDLE;
                end else begin
                    tx_start = 1'b1;
                    tx_byte  = rdata[23:16];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // APB outputs load only on the byte that completes a command, then hold
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            byte_cnt  <= 2'd0;
            resp_left <= 2'd0;
            addr_sh   <= '0;
            data_sh   <= '0;
            rdata     <= '0;
            tmo_cnt   <= '0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
        end else begin
            state   <= state_next;
            tmo_cnt <= '0;
            case (state)
                IDLE: if (rx_valid) begin
                    is_write  <= (rx_shift == CMD_W);
                    byte_cnt  <= 2'd0;
                    resp_left <= 2'd0;
                end
                ADDR: begin
                    if (rx_valid) begin
                        addr_sh  <= {addr_sh[11:0], rx_shift};
                        byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
                        if (byte_cnt == 2'd2 && !is_write) begin
                            paddr  <= {addr_sh[11:0], rx_shift};
                            pwrite <= 1'b0;
                        end
                    end else if (TIMEOUT_CLKS != 0) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        data_sh  <= {data_sh[15:0], rx_shift};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            paddr  <= addr_sh;
                            pwrite <= 1'b1;
                            pwdata <= {data_sh, rx_shift};
                        end
                    end else if (TIMEOUT_CLKS != 0) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ACCESS: begin
                    rdata     <= prdata[23:0];
                    resp_left <= is_write ? 2'd0 : 2'd3;
                end
                RESP: if (tx_done && resp_left != 2'd0) begin
                    rdata     <= {rdata[15:0], 8'h00};
                    resp_left <= resp_left - 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign psel    = (state == SETUP) || (state == ACCESS);
    assign penable = (state == ACCESS);
endmodule

// File: doc/uart_apb_bridge.md
# uart_apb_bridge

UART-to-APB master bridge that lets a host PC load program RAM and drive the core-control CSR of the flunkyfive subsystem over a serial cable. It sits directly upstream of the flunkyfive APB slave port and owns `paddr`/`psel`/`penable`/`pwrite`/`pwdata`. It receives framed byte commands on `uart_rx`, issues one APB transfer per command, and returns an acknowledge or read data on `uart_tx`.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per UART bit (50 MHz / 115200). Minimum 4.
- `TIMEOUT_CLKS`, default 1000000: maximum idle gap between bytes inside one command before the command is aborted. 0 disables the timeout.

- `clk` input 1: clock.
- `resetn` input 1: reset, asynchronous, active-low.
- `uart_rx` input 1: serial in, 8N1, LSB first, idle high, asynchronous to clk.
- `uart_tx` output 1: serial out, 8N1, LSB first, idle high.
- `paddr` output 20: APB address.
- `pwrite` output 1: APB direction, 1 = write.
- `psel` output 1: APB select.
- `penable` output 1: APB enable.
- `pwdata` output 32: APB write data.
- `prdata` input 32: APB read data, sampled in the ACCESS cycle.
- `busy` output 1: high whenever the command FSM is not in IDLE.

## Operation
- Reset values:
  - `uart_tx`=1.
  - `psel`, `penable`, `pwrite`, `busy` = 0.
  - `paddr`=0, `pwdata`=0.
  - FSM in IDLE; RX/TX shifters idle; timeout counter cleared.
- RX path:
  - `uart_rx` passes through a 2-flop synchronizer.
  - A falling edge while RX is idle starts a frame.
  - The start bit is re-checked at mid-bit (CLKS_PER_BIT/2); if it reads high, the frame is a glitch and is dropped.
  - Data bits are sampled at mid-bit.
  - If the stop bit is 1 at mid-bit, a 1-cycle `rx_valid` pulse is produced and RX returns to hunting for the next start bit.
  - If the stop bit is 0 (framing error), the byte is discarded and no `rx_valid` is produced.
- Protocol (multi-byte fields big-endian):
  - Write command: 0x57 'W', A2 A1 A0, D3 D2 D1 D0. `paddr` = {A2[3:0],A1,A0}; A2[7:4] are ignored. Response is one byte, 0x06.
  - Read command: 0x52 'R', A2 A1 A0. Response is `prdata` as 4 bytes, MSB first.
  - Any other first byte: response is 0x15 (NAK); FSM returns to IDLE.
- FSM states and transitions:
  - IDLE: waits for the command byte.
  - ADDR: collects 3 address bytes.
  - DATA: collects 4 data bytes (writes only).
  - SETUP: `psel`=1, `penable`=0.
  - ACCESS: `psel`=1, `penable`=1. Read data is captured here.
  - RESP: transmits 1, 4 or 1 bytes (write ack, read data, NAK).
  - RESP returns to IDLE.
- No `pready`: every transfer is exactly one SETUP cycle plus one ACCESS cycle.
- `paddr`, `pwrite` and `pwdata` are stable from SETUP through ACCESS. They hold their last values afterwards; they are not cleared.
- Bytes received in SETUP, ACCESS or RESP are discarded. No buffering.
- Timeout:
  - In ADDR or DATA, the counter is reset on each `rx_valid` and increments every cycle.
  - When it reaches TIMEOUT_CLKS, the FSM goes to IDLE, no APB transfer occurs, and nothing is transmitted.
  - A framing error inside a command does not abort it; the timeout eventually does.

## Timing
- Last command byte `rx_valid` (cycle N): FSM enters SETUP at N+1, so `psel` rises at N+1.
- `penable`=1 at N+2; `psel` and `penable` both fall at N+3.
- `prdata` is registered at the end of cycle N+2.
- TX start bit begins at N+3 (`uart_tx` low from N+3).
- NAK case: TX start bit begins at N+1 after the bad command byte.
- Each TX byte is exactly 10×CLKS_PER_BIT cycles.
- Multi-byte responses are back-to-back with no idle gap.
- `busy` falls in the cycle after the stop bit of the last response byte completes.
- Reset mid-operation: asserting `resetn` low at any point forces all reset values immediately (asynchronous). This includes mid-APB-access (`psel`/`penable` drop) and mid-TX (`uart_tx` goes high).

## Test plan
Benches use CLKS_PER_BIT=8 and TIMEOUT_CLKS=200.
- Write: send 57 01 00 04 DE AD BE EF -> one SETUP/ACCESS pair with `paddr`=0x10004, `pwrite`=1, `pwdata`=0xDEADBEEF; `psel` high for exactly 2 cycles; TX returns 0x06.
- Read: drive `prdata`=0x12345678 and send 52 00 00 10 -> `paddr`=0x00010, `pwrite`=0; TX returns 12 34 56 78 back-to-back, 320 cycles total; `busy` drops after.
- Address mask: write with A2=0xF1 -> `paddr`=0x1xxxx. Unknown command 0x41 -> TX 0x15, no `psel` activity.
- Framing error and glitch: a byte with stop bit 0 -> no `rx_valid`, FSM stays IDLE. A 2-cycle low glitch on `uart_rx` -> no byte received.
- Timeout: send 57 00 00, then wait 250 cycles -> FSM in IDLE, no APB transfer, `uart_tx` stays 1. A following full write completes normally.
- Reset: assert `resetn` during ACCESS of a write and again mid-TX of a read response -> all outputs at reset values the same cycle; a fresh command afterwards succeeds.
